// File: rtl/ex_mem_reg_pkg.sv
// Shared types for the EX/MEM pipeline register: field widths, flag bit
// positions, branch condition codes and the registered pipeline-slot layout.
package ex_mem_reg_pkg;

    localparam int DATA_W = 16;
    localparam int FLAG_W = 3;
    localparam int DST_W  = 4;
    localparam int BOP_W  = 3;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [BOP_W-1:0] {
        BNEQ    = 3'd0,
        BEQ     = 3'd1,
        BGT     = 3'd2,
        BLT     = 3'd3,
        BGTE    = 3'd4,
        BLTE    = 3'd5,
        BOVFL   = 3'd6,
        BUNCOND = 3'd7
    } branch_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] memAddr;
        logic [DATA_W-1:0] wrData;
        logic [BOP_W-1:0]  branchOp;
        logic [DST_W-1:0]  dst;
        logic              memToReg;
        logic              memValid;
        logic              memWr;
        logic              memRd;
        logic              sawBr;
        logic              sawJ;
        logic              regWe;
    } slot_t;

    // A slot is only allowed to carry side-effecting controls when it is valid.
    function automatic logic gateCtrl(input logic valid, input logic ctrl);
        return valid & ctrl;
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM register, grouped as one bus.
interface ex_mem_reg_if #(parameter int CNT_W = 16);
    import ex_mem_reg_pkg::*;

    logic              stall;
    logic              flush;
    logic              exValid;
    logic [DATA_W-1:0] exAluOut;
    logic [DATA_W-1:0] exStData;
    logic [FLAG_W-1:0] exFlags;
    logic              exSetFlags;
    logic              exMemWr;
    logic              exMemRd;
    logic              exSawBr;
    logic              exSawJ;
    logic              exRegWe;
    logic              exMemToReg;
    logic [BOP_W-1:0]  exBranchOp;
    logic [DST_W-1:0]  exDst;

    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] wrData;
    logic [FLAG_W-1:0] flags;
    logic              memWr;
    logic              memRd;
    logic              sawBr;
    logic              sawJ;
    logic              regWe;
    logic              memToReg;
    logic              memValid;
    logic [BOP_W-1:0]  branchOp;
    logic [DST_W-1:0]  dst;
    logic [CNT_W-1:0]  retired;

    modport master (
        output stall, flush, exValid, exAluOut, exStData, exFlags, exSetFlags,
               exMemWr, exMemRd, exSawBr, exSawJ, exRegWe, exMemToReg,
               exBranchOp, exDst,
        input  memAddr, wrData, flags, memWr, memRd, sawBr, sawJ, regWe,
               memToReg, memValid, branchOp, dst, retired
    );

    modport slave (
        input  stall, flush, exValid, exAluOut, exStData, exFlags, exSetFlags,
               exMemWr, exMemRd, exSawBr, exSawJ, exRegWe, exMemToReg,
               exBranchOp, exDst,
        output memAddr, wrData, flags, memWr, memRd, sawBr, sawJ, regWe,
               memToReg, memValid, branchOp, dst, retired
    );

endinterface

// File: rtl/ex_mem_reg_flag_reg.sv
// Architectural N/Z/V flag register: 3-bit load-enable register with sync reset.
module flag_reg
    import ex_mem_reg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [FLAG_W-1:0] d,
    output logic [FLAG_W-1:0] q
);

    logic [FLAG_W-1:0] flags_r;

    // Reset wins over enable; otherwise load or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= 3'b000;
        end else if (en) begin
            flags_r <= d;
        end else begin
            flags_r <= flags_r;
        end
    end

    assign q = flags_r;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush/stall handling, the architectural flag
// register and a saturating retired-instruction counter.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_reg_if.slave  bus
);

    slot_t            slot_r;
    slot_t            slotNext_s;
    logic             load_s;
    logic             flagLoad_s;
    logic [CNT_W-1:0] retired_r;

    assign load_s     = ~bus.flush & ~bus.stall;
    assign flagLoad_s = load_s & bus.exValid & bus.exSetFlags;

    // Next slot contents: flush makes a bubble, stall holds, else capture EX.
    always_comb begin
        slotNext_s = slot_r;
        if (bus.flush) begin
            slotNext_s = '0;
        end else if (bus.stall) begin
            slotNext_s = slot_r;
        end else begin
            slotNext_s.memAddr  = bus.exAluOut;
            slotNext_s.wrData   = bus.exStData;
            slotNext_s.branchOp = bus.exBranchOp;
            slotNext_s.dst      = bus.exDst;
            slotNext_s.memToReg = bus.exMemToReg;
            slotNext_s.memValid = bus.exValid;
            slotNext_s.memWr    = gateCtrl(bus.exValid, bus.exMemWr);
            slotNext_s.memRd    = gateCtrl(bus.exValid, bus.exMemRd);
            slotNext_s.sawBr    = gateCtrl(bus.exValid, bus.exSawBr);
            slotNext_s.sawJ     = gateCtrl(bus.exValid, bus.exSawJ);
            slotNext_s.regWe    = gateCtrl(bus.exValid, bus.exRegWe);
        end
    end

    // Pipeline slot register.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r <= '0;
        end else begin
            slot_r <= slotNext_s;
        end
    end

    // Retired counter: counts accepted valid instructions, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_r <= '0;
        end else if (load_s && bus.exValid && !(&retired_r)) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

    flag_reg u_flag_reg (
        .clk (clk),
        .rst (rst),
        .en  (flagLoad_s),
        .d   (bus.exFlags),
        .q   (bus.flags)
    );

    assign bus.memAddr  = slot_r.memAddr;
    assign bus.wrData   = slot_r.wrData;
    assign bus.branchOp = slot_r.branchOp;
    assign bus.dst      = slot_r.dst;
    assign bus.memToReg = slot_r.memToReg;
    assign bus.memValid = slot_r.memValid;
    assign bus.memWr    = slot_r.memWr;
    assign bus.memRd    = slot_r.memRd;
    assign bus.sawBr    = slot_r.sawBr;
    assign bus.sawJ     = slot_r.sawJ;
    assign bus.regWe    = slot_r.regWe;
    assign bus.retired  = retired_r;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed-vector bench for ex_mem_reg with hand-computed expectations.
module tb_ex_mem_reg;
    import ex_mem_reg_pkg::*;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errCnt = 0;
    int   chkCnt = 0;

    always #5 clk = ~clk;

    ex_mem_reg_if #(.CNT_W(CNT_W)) bus ();

    ex_mem_reg #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearEx();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.exValid = 1'b0;
        bus.exAluOut = 16'h0000; bus.exStData = 16'h0000; bus.exFlags = 3'b000;
        bus.exSetFlags = 1'b0; bus.exMemWr = 1'b0; bus.exMemRd = 1'b0;
        bus.exSawBr = 1'b0; bus.exSawJ = 1'b0; bus.exRegWe = 1'b0;
        bus.exMemToReg = 1'b0; bus.exBranchOp = 3'd0; bus.exDst = 4'd0;
    endtask

    initial begin
        // Reset with every EX input nonzero.
        clearEx();
        bus.exValid = 1'b1; bus.exAluOut = 16'hFFFF; bus.exStData = 16'hBEEF;
        bus.exFlags = 3'b111; bus.exSetFlags = 1'b1; bus.exMemWr = 1'b1;
        bus.exMemRd = 1'b1; bus.exSawBr = 1'b1; bus.exSawJ = 1'b1;
        bus.exRegWe = 1'b1; bus.exMemToReg = 1'b1; bus.exBranchOp = 3'd7;
        bus.exDst = 4'hF;
        rst = 1'b1;
        tick(); tick();
        checkVal("rst_memAddr", 32'(bus.memAddr), 32'h0);
        checkVal("rst_wrData", 32'(bus.wrData), 32'h0);
        checkVal("rst_flags", 32'(bus.flags), 32'h0);
        checkVal("rst_ctrl", 32'({bus.memWr, bus.memRd, bus.sawBr, bus.sawJ,
                 bus.regWe, bus.memToReg, bus.memValid}), 32'h0);
        checkVal("rst_dst_bop", 32'({bus.dst, bus.branchOp}), 32'h0);
        checkVal("rst_retired", 32'(bus.retired), 32'h0);

        // Normal load.
        rst = 1'b0;
        clearEx();
        bus.exValid = 1'b1; bus.exAluOut = 16'h1234; bus.exMemRd = 1'b1; bus.exDst = 4'd5;
        tick();
        checkVal("ld_memAddr", 32'(bus.memAddr), 32'h1234);
        checkVal("ld_memRd", 32'(bus.memRd), 32'h1);
        checkVal("ld_memWr", 32'(bus.memWr), 32'h0);
        checkVal("ld_dst", 32'(bus.dst), 32'h5);
        checkVal("ld_memValid", 32'(bus.memValid), 32'h1);
        checkVal("ld_retired", 32'(bus.retired), 32'h1);

        // Flag setter then non-setter, then a BEQ branch.
        clearEx();
        bus.exValid = 1'b1; bus.exSetFlags = 1'b1; bus.exFlags = 3'b010;
        tick();
        checkVal("fl_set", 32'(bus.flags), 32'h2);
        bus.exSetFlags = 1'b0; bus.exFlags = 3'b100;
        tick();
        checkVal("fl_noset", 32'(bus.flags), 32'h2);
        clearEx();
        bus.exValid = 1'b1; bus.exSawBr = 1'b1; bus.exBranchOp = BEQ;
        tick();
        checkVal("br_sawBr", 32'(bus.sawBr), 32'h1);
        checkVal("br_op", 32'(bus.branchOp), 32'(BEQ));
        checkVal("br_flags", 32'(bus.flags), 32'h2);
        checkVal("br_retired", 32'(bus.retired), 32'h4);

        // Flush beats stall.
        clearEx();
        bus.flush = 1'b1; bus.stall = 1'b1; bus.exValid = 1'b1; bus.exMemWr = 1'b1;
        bus.exSetFlags = 1'b1; bus.exFlags = 3'b111; bus.exAluOut = 16'h7777;
        tick();
        checkVal("fs_memWr", 32'(bus.memWr), 32'h0);
        checkVal("fs_memValid", 32'(bus.memValid), 32'h0);
        checkVal("fs_sawBr", 32'(bus.sawBr), 32'h0);
        checkVal("fs_memAddr", 32'(bus.memAddr), 32'h0);
        checkVal("fs_flags", 32'(bus.flags), 32'h2);
        checkVal("fs_retired", 32'(bus.retired), 32'h4);

        // Known load, then three stalled cycles with changing inputs.
        clearEx();
        bus.exValid = 1'b1; bus.exAluOut = 16'hAAAA; bus.exMemWr = 1'b1; bus.exDst = 4'd9;
        tick();
        checkVal("pre_memAddr", 32'(bus.memAddr), 32'hAAAA);
        checkVal("pre_retired", 32'(bus.retired), 32'h5);
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1; bus.exAluOut = 16'h1000 + 16'(i); bus.exDst = 4'(i);
            bus.exSetFlags = 1'b1; bus.exFlags = 3'b101; bus.exMemWr = 1'b0;
            tick();
            checkVal("st_memAddr", 32'(bus.memAddr), 32'hAAAA);
            checkVal("st_dst", 32'(bus.dst), 32'h9);
            checkVal("st_memWr", 32'(bus.memWr), 32'h1);
            checkVal("st_flags", 32'(bus.flags), 32'h2);
            checkVal("st_retired", 32'(bus.retired), 32'h5);
        end
        bus.stall = 1'b0; bus.exAluOut = 16'h5555; bus.exDst = 4'd3;
        tick();
        checkVal("rel_memAddr", 32'(bus.memAddr), 32'h5555);
        checkVal("rel_flags", 32'(bus.flags), 32'h5);
        checkVal("rel_retired", 32'(bus.retired), 32'h6);

        // Invalid slot: controls gated, data copied, flags and counter hold.
        clearEx();
        bus.exValid = 1'b0; bus.exMemWr = 1'b1; bus.exRegWe = 1'b1; bus.exSawJ = 1'b1;
        bus.exSetFlags = 1'b1; bus.exFlags = 3'b011; bus.exAluOut = 16'h0C0C;
        tick();
        checkVal("inv_ctrl", 32'({bus.memWr, bus.regWe, bus.sawJ, bus.memValid}), 32'h0);
        checkVal("inv_memAddr", 32'(bus.memAddr), 32'h0C0C);
        checkVal("inv_flags", 32'(bus.flags), 32'h5);
        checkVal("inv_retired", 32'(bus.retired), 32'h6);

        // Counter saturation: 6 already counted, 65529 more reaches all-ones.
        clearEx();
        bus.exValid = 1'b1;
        repeat (65529) @(posedge clk);
        #1;
        checkVal("sat_reach", 32'(bus.retired), 32'hFFFF);
        tick();
        checkVal("sat_hold", 32'(bus.retired), 32'hFFFF);

        // Reset during stall and flush clears everything.
        bus.stall = 1'b1; bus.flush = 1'b1; rst = 1'b1;
        tick();
        checkVal("rstst_retired", 32'(bus.retired), 32'h0);
        checkVal("rstst_flags", 32'(bus.flags), 32'h0);
        checkVal("rstst_valid", 32'(bus.memValid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
